// File: rtl/led_pwm_fader.sv
// led_pwm_fader: turns an on/off request into a ramped brightness level
// and a PWM drive whose duty follows that level.
// Optional build macro: LED_FADE_GAMMA_EN (square-law duty mapping).
module led_pwm_fader #(
    parameter logic [63:0] CLK_RATE = 64'd100000000,
    parameter logic [63:0] RAMP_MS  = 64'd250,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                led_in,
    output logic                led_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam logic [63:0] MAX64       = (64'd1 << PWM_BITS) - 64'd1;
    localparam logic [63:0] STEP_RAW    = (CLK_RATE * RAMP_MS) / (64'd1000 * MAX64);
    localparam logic [63:0] STEP_CYCLES = (STEP_RAW == 64'd0) ? 64'd1 : STEP_RAW;
    localparam int unsigned CNT_W       = (STEP_CYCLES > 64'd1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(STEP_CYCLES - 64'd1);
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST  = MAX - PWM_BITS'(1);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_step_cnt;
    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_led_pwm;

    logic                w_step_wrap;
    logic [PWM_BITS-1:0] w_level_inc;
    logic [PWM_BITS-1:0] w_level_dec;
    logic [PWM_BITS-1:0] w_duty;

    // Saturating neighbours of the current level and the step-counter wrap point
    assign w_step_wrap = (r_step_cnt == STEP_LAST);
    assign w_level_inc = (r_level == MAX) ? MAX : (r_level + PWM_BITS'(1));
    assign w_level_dec = (r_level == '0) ? '0 : (r_level - PWM_BITS'(1));

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_level_ext;
    logic [2*PWM_BITS-1:0] w_level_sq;

    // Square-law duty for a perceptually even fade; full scale stays full scale
    assign w_level_ext = {{PWM_BITS{1'b0}}, r_level};
    assign w_level_sq  = w_level_ext * w_level_ext;
    assign w_duty      = (r_level == MAX) ? MAX : PWM_BITS'(w_level_sq >> PWM_BITS);
`else
    // Linear duty: brightness level drives the PWM compare directly
    assign w_duty = r_level;
`endif

    // Fade state machine: steps the level once every STEP_CYCLES while ramping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_OFF;
            r_level    <= '0;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    r_level <= '0;
                    if (led_in) begin
                        r_state    <= S_RAMP_UP;
                        r_step_cnt <= '0;
                    end
                end
                S_RAMP_UP: begin
                    if (!led_in) begin
                        r_state    <= S_RAMP_DOWN;
                        r_step_cnt <= '0;
                    end else if (w_step_wrap) begin
                        r_step_cnt <= '0;
                        r_level    <= w_level_inc;
                        if (w_level_inc == MAX) begin
                            r_state <= S_ON;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + CNT_W'(1);
                    end
                end
                S_ON: begin
                    r_level <= MAX;
                    if (!led_in) begin
                        r_state    <= S_RAMP_DOWN;
                        r_step_cnt <= '0;
                    end
                end
                S_RAMP_DOWN: begin
                    if (led_in) begin
                        r_state    <= S_RAMP_UP;
                        r_step_cnt <= '0;
                    end else if (w_step_wrap) begin
                        r_step_cnt <= '0;
                        r_level    <= w_level_dec;
                        if (w_level_dec == '0) begin
                            r_state <= S_OFF;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= S_OFF;
                    r_level    <= '0;
                    r_step_cnt <= '0;
                end
            endcase
        end
    end

    // PWM generator: duty latched only at the period boundary to avoid glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
            r_led_pwm <= 1'b0;
        end else begin
            if (r_pwm_cnt == PWM_LAST) begin
                r_pwm_cnt <= '0;
                r_duty    <= w_duty;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end
            r_led_pwm <= (r_pwm_cnt < r_duty);
        end
    end

    assign led_pwm = r_led_pwm;
    assign level   = r_level;
    assign busy    = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader with PWM_BITS=4, STEP_CYCLES=10.
module tb_led_pwm_fader;

    logic       clk;
    logic       rst;
    logic       led_in;
    logic       led_pwm;
    logic [3:0] level;
    logic       busy;

    int vectors;
    int miscompares;

    led_pwm_fader #(
        .CLK_RATE (64'd15000),
        .RAMP_MS  (64'd10),
        .PWM_BITS (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_in  (led_in),
        .led_pwm (led_pwm),
        .level   (level),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected PWM high cycles per 15-cycle period for a held level
    function automatic int exp_duty(input int l);
`ifdef LED_FADE_GAMMA_EN
        if (l == 15) return 15;
        return (l * l) >> 4;
`else
        return l;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Ramp until the level reaches a target, bounded by a cycle budget
    task automatic wait_level(input int target, input int budget);
        int n;
        n = 0;
        while ((32'(level) != 32'(target)) && (n < budget)) begin
            tick();
            n++;
        end
        chk("wait_level", 32'(level), 32'(target));
    endtask

    // Hold the level by reversing every cycle, then count PWM highs per period
    task automatic hold_measure(input int l);
        int hi;
        for (int i = 0; i < 30; i++) begin
            led_in = ~led_in;
            tick();
            chk("hold_level", 32'(level), 32'(l));
        end
        for (int w = 0; w < 3; w++) begin
            hi = 0;
            for (int i = 0; i < 15; i++) begin
                led_in = ~led_in;
                tick();
                chk("hold_level", 32'(level), 32'(l));
                hi += int'(led_pwm);
            end
            chk("pwm_highs", 32'(hi), 32'(exp_duty(l)));
        end
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        led_in      = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pwm", 32'(led_pwm), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Idle with request low
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("idle_level", 32'(level), 32'd0);
            chk("idle_pwm", 32'(led_pwm), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Full ramp up from 0 to 15
        led_in = 1'b1;
        tick();
        chk("up_busy", 32'(busy), 32'd1);
        chk("up_level0", 32'(level), 32'd0);
        repeat (9) tick();
        chk("up_pre_step", 32'(level), 32'd0);
        tick();
        chk("up_first_step", 32'(level), 32'd1);
        repeat (139) tick();
        chk("up_level14", 32'(level), 32'd14);
        chk("up_busy14", 32'(busy), 32'd1);
        tick();
        chk("up_level15", 32'(level), 32'd15);
        chk("on_busy", 32'(busy), 32'd0);
        repeat (30) tick();
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("on_pwm_full", 32'(led_pwm), 32'd1);
        end

        // Full ramp down from 15 to 0
        led_in = 1'b0;
        tick();
        chk("dn_busy", 32'(busy), 32'd1);
        chk("dn_level15", 32'(level), 32'd15);
        n = 0;
        while ((busy === 1'b1) && (n < 300)) begin
            tick();
            n++;
        end
        chk("dn_cycles", 32'(n), 32'd150);
        chk("dn_level0", 32'(level), 32'd0);
        chk("dn_busy_end", 32'(busy), 32'd0);

        // Ramp to 7 then reverse: level held, then decrements to 0
        led_in = 1'b1;
        tick();
        repeat (70) tick();
        chk("mid_level7", 32'(level), 32'd7);
        chk("mid_busy", 32'(busy), 32'd1);
        led_in = 1'b0;
        tick();
        chk("rev_hold7", 32'(level), 32'd7);
        chk("rev_busy", 32'(busy), 32'd1);
        repeat (9) tick();
        chk("rev_pre_step", 32'(level), 32'd7);
        tick();
        chk("rev_level6", 32'(level), 32'd6);
        repeat (59) tick();
        chk("rev_level1", 32'(level), 32'd1);
        chk("rev_busy1", 32'(busy), 32'd1);
        tick();
        chk("rev_level0", 32'(level), 32'd0);
        chk("rev_off_busy", 32'(busy), 32'd0);

        // Reversal on the wrap cycle wins; ramp-down saturates at 0
        led_in = 1'b1;
        tick();
        repeat (9) tick();
        led_in = 1'b0;
        tick();
        chk("wrap_rev_level", 32'(level), 32'd0);
        chk("wrap_rev_busy", 32'(busy), 32'd1);
        repeat (9) tick();
        chk("sat_busy_pre", 32'(busy), 32'd1);
        tick();
        chk("sat_busy_off", 32'(busy), 32'd0);
        chk("sat_level", 32'(level), 32'd0);

        // Duty 0 keeps the pin low
        repeat (30) tick();
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("off_pwm_zero", 32'(led_pwm), 32'd0);
        end

        // Held-level PWM duty at several levels
        led_in = 1'b1;
        tick();
        wait_level(3, 100);
        hold_measure(3);
        led_in = 1'b1;
        wait_level(5, 200);
        hold_measure(5);
        led_in = 1'b1;
        wait_level(8, 200);
        hold_measure(8);

        // Reset mid ramp-up at level 9, then restart from 0
        led_in = 1'b1;
        wait_level(9, 200);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_pwm", 32'(led_pwm), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_level", 32'(level), 32'd0);
        repeat (9) tick();
        chk("restart_pre_step", 32'(level), 32'd0);
        tick();
        chk("restart_step", 32'(level), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Downstream consumer of the LED flasher's on/off output.
- Turns the hard on/off request into a smooth "breathing" LED:
  - ramps a brightness level up while the request is high, and down while it is low;
  - drives the pin with a PWM signal whose duty cycle tracks that level.
- Sits between the flasher and the board LED pin, in the same clock domain.

Parameters:
- CLK_RATE, 100000000, clock frequency in Hz (64-bit).
- RAMP_MS, 250, time in ms for a full-scale ramp from 0 to MAX (64-bit).
- PWM_BITS, 8, brightness/duty width; MAX = 2**PWM_BITS-1.
- STEP_CYCLES, derived = CLK_RATE*RAMP_MS/(1000*MAX), forced to 1 if it computes to 0; clock cycles per level step.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- led_in  input  1  on/off request from the flasher, synchronous to clk.
- led_pwm  output  1  PWM drive to the LED pin, registered.
- level  output  PWM_BITS  current brightness level.
- busy  output  1  high while ramping (state RAMP_UP or RAMP_DOWN).

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high, sampled on posedge clk. It overrides all other activity, including mid-ramp.
- Reset values:
  - state=OFF, level=0, step counter=0, pwm_counter=0, duty_reg=0;
  - led_pwm=0, busy=0.
- State machine: OFF, RAMP_UP, ON, RAMP_DOWN.
  - OFF: level=0. If led_in=1, go to RAMP_UP and clear the step counter.
  - RAMP_UP:
    - The step counter counts 0..STEP_CYCLES-1. At STEP_CYCLES-1 it wraps to 0 and level increments by 1.
    - On the edge where level becomes MAX, go to ON.
    - If led_in=0, go to RAMP_DOWN and clear the step counter. Level is held; there is no jump.
  - ON: level=MAX. If led_in=0, go to RAMP_DOWN and clear the step counter.
  - RAMP_DOWN:
    - Mirror of RAMP_UP with decrement.
    - Go to OFF on the edge where level becomes 0.
    - If led_in=1, go to RAMP_UP and clear the step counter.
- Level arithmetic saturates: it never wraps below 0 or above MAX.
- Direction reversal and step-counter wrap on the same cycle: the reversal wins and level is unchanged that cycle.
- Timing:
  - Level first changes exactly STEP_CYCLES cycles after the state enters a ramp state.
  - A full ramp takes MAX*STEP_CYCLES cycles.
  - Input-to-state latency is 1 cycle.
- PWM:
  - pwm_counter is free-running 0..MAX-1 (period MAX cycles).
  - duty_reg loads the duty value only when pwm_counter==MAX-1, so duty changes take effect at a period boundary with no mid-period glitch.
  - led_pwm <= (pwm_counter < duty_reg), registered.
  - duty 0 means led_pwm is constantly 0; duty MAX means it is constantly 1.
- busy: combinational from the state register.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty = (level*level) >> PWM_BITS, with level==MAX mapped to MAX. The multiply is 2*PWM_BITS wide. This gives a perceptually linear fade.
- Undefined: duty = level (linear), and no multiplier is instantiated.
- The level output and all state and timing behaviour are identical in both builds.

Test Plan:
Test parameters: PWM_BITS=4 (MAX=15), CLK_RATE=15000, RAMP_MS=10, giving STEP_CYCLES=10.
- Reset, led_in=0 for 200 cycles -> level=0, led_pwm=0, busy=0 throughout.
- led_in 0->1 and held -> busy=1 from the next cycle. level=1 exactly 10 cycles after entering RAMP_UP, and level=15 after 150 cycles. State goes to ON and busy=0 on the same edge. led_pwm is then constantly 1.
- Ramp up to level=7, then led_in=0 -> level holds 7, decrements to 6 10 cycles later, and reaches 0 after 70 cycles. State goes to OFF, busy=0.
- Linear build, level held at 5 (freeze led_in toggling at that point) -> each 15-cycle PWM period shows exactly 5 high cycles. duty_reg only changes when pwm_counter==14.
- Assert rst mid-RAMP_UP at level=9 -> next cycle: level=0, led_pwm=0, busy=0, state=OFF. After rst is released with led_in=1, the ramp restarts from 0.
- LED_FADE_GAMMA_EN defined: level=8 -> duty=4 (64>>4); level=15 -> duty=15; level=3 -> duty=0, so led_pwm stays 0.
